p20_obstacle_spawner: RTL and testbench

Consumer end of the cactus LFSR. Drives the LFSR advance strobe, uses each 5-bit random value to choose spawn gaps and cactus types, and maintains a small set of scrolling obstacle slots (x position, type, valid). Sits between the LFSR and the renderer/collision logic. Collision and drawing are handled elsewhere.

---
 rtl/p20_pkg.sv | 18 +
 rtl/p20_obstacle_slot.sv | 44 ++++
 rtl/p20_obstacle_spawner.sv | 102 ++++++++++
 tb/tb_p20_obstacle_spawner.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/p20_pkg.sv
// Shared definitions for the cactus obstacle spawner: FSM encoding, cactus types, defaults.
package p20_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_COUNT = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [1:0] OBS_SMALL  = 2'd0;
    localparam logic [1:0] OBS_TALL   = 2'd1;
    localparam logic [1:0] OBS_DOUBLE = 2'd2;
    localparam logic [1:0] OBS_TRIPLE = 2'd3;

    localparam int unsigned SPAWN_X_DEF = 640;
    localparam int unsigned GAP_W       = 6;

endpackage

// File: rtl/p20_obstacle_slot.sv
// One scrolling obstacle slot: spawn load, per-tick leftward move, clear once off-screen.
module p20_obstacle_slot
    import p20_pkg::*;
#(
    parameter int unsigned XW      = 10,
    parameter int unsigned SPAWN_X = SPAWN_X_DEF
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic          tick,
    input  logic          spawn,
    input  logic [1:0]    spawn_type,
    input  logic [2:0]    speed,
    output logic          valid,
    output logic [XW-1:0] x,
    output logic [1:0]    obs_type
);

    logic [XW-1:0] step_c;
    assign step_c = XW'(speed);

    // A slot reaching x==0 stays visible for one tick; it clears once speed exceeds x.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            valid    <= 1'b0;
            x        <= '0;
            obs_type <= OBS_SMALL;
        end else if (tick) begin
            if (spawn) begin
                valid    <= 1'b1;
                x        <= XW'(SPAWN_X);
                obs_type <= spawn_type;
            end else if (valid) begin
                if (x >= step_c) begin
                    x <= x - step_c;
                end else begin
                    valid <= 1'b0;
                    x     <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/p20_obstacle_spawner.sv
// Cactus spawner: draws gaps/types from the LFSR, stalls when all slots are busy, drives the slots.
module p20_obstacle_spawner
    import p20_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 2,
    parameter int unsigned XW        = 10,
    parameter int unsigned SPAWN_X   = SPAWN_X_DEF,
    parameter int unsigned MIN_GAP   = 8
) (
    input  logic                    clk,
    input  logic                    sys_rst,
    input  logic                    frame_tick,
    input  logic                    game_run,
    input  logic [2:0]              speed,
    input  logic [4:0]              rng_val,
    output logic                    rng_step,
    output logic                    spawn_pulse,
    output logic [NUM_SLOTS-1:0]    obs_valid,
    output logic [NUM_SLOTS*XW-1:0] obs_x,
    output logic [2*NUM_SLOTS-1:0]  obs_type
);

    state_t             state;
    logic [GAP_W-1:0]   gap_cnt;
    logic               tick_c;
    logic               free_any_c;
    logic               do_spawn_c;
    logic [NUM_SLOTS-1:0] spawn_sel_c;

    assign tick_c = frame_tick & game_run;

    // Lowest-index free slot, taken from the valid flags before this tick's move.
    always_comb begin
        spawn_sel_c = '0;
        free_any_c  = 1'b0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (!obs_valid[i] && !free_any_c) begin
                spawn_sel_c[i] = 1'b1;
                free_any_c     = 1'b1;
            end
        end
    end

    assign do_spawn_c = tick_c && free_any_c &&
                        ((state == ST_COUNT && gap_cnt <= GAP_W'(1)) || state == ST_STALL);

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state       <= ST_LOAD;
            gap_cnt     <= '0;
            rng_step    <= 1'b0;
            spawn_pulse <= 1'b0;
        end else begin
            rng_step    <= 1'b0;
            spawn_pulse <= 1'b0;
            case (state)
                ST_LOAD: begin
                    gap_cnt  <= GAP_W'(MIN_GAP) + GAP_W'(rng_val);
                    rng_step <= 1'b1;
                    state    <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (tick_c) begin
                        if (gap_cnt > GAP_W'(1)) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end else if (do_spawn_c) begin
                            spawn_pulse <= 1'b1;
                            state       <= ST_LOAD;
                        end else begin
                            state <= ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    if (do_spawn_c) begin
                        spawn_pulse <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    for (genvar i = 0; i < int'(NUM_SLOTS); i++) begin : g_slot
        p20_obstacle_slot #(
            .XW      (XW),
            .SPAWN_X (SPAWN_X)
        ) u_slot (
            .clk        (clk),
            .sys_rst    (sys_rst),
            .tick       (tick_c),
            .spawn      (do_spawn_c && spawn_sel_c[i]),
            .spawn_type (rng_val[1:0]),
            .speed      (speed),
            .valid      (obs_valid[i]),
            .x          (obs_x[i*XW +: XW]),
            .obs_type   (obs_type[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_p20_obstacle_spawner.sv
// Directed bench for p20_obstacle_spawner: tick-row vector table plus reset sequences.
module tb_p20_obstacle_spawner;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        game_run = 1'b0;
    logic [2:0]  speed = 3'd0;
    logic [4:0]  rng_val = 5'd1;
    logic        rng_step;
    logic        spawn_pulse;
    logic [1:0]  obs_valid;
    logic [19:0] obs_x;
    logic [3:0]  obs_type;

    int checks = 0;
    int failures = 0;
    int spawn_seen;
    int step_seen;

    always #5 clk = ~clk;

    p20_obstacle_spawner #(
        .NUM_SLOTS (2),
        .XW        (10),
        .SPAWN_X   (640),
        .MIN_GAP   (8)
    ) dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .frame_tick  (frame_tick),
        .game_run    (game_run),
        .speed       (speed),
        .rng_val     (rng_val),
        .rng_step    (rng_step),
        .spawn_pulse (spawn_pulse),
        .obs_valid   (obs_valid),
        .obs_x       (obs_x),
        .obs_type    (obs_type)
    );

    // n ticks (each a tick cycle then an idle cycle); expectations hold after the last one
    typedef struct {
        int         n;
        logic       run;
        logic [2:0] spd;
        logic [4:0] rng;
        int         spawns;
        int         steps;
        logic [1:0] valid;
        int         x0;
        int         x1;
        logic [1:0] t0;
        logic [1:0] t1;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic cycle(input logic ft);
        frame_tick = ft;
        @(posedge clk);
        #1;
        spawn_seen += int'(spawn_pulse);
        step_seen  += int'(rng_step);
    endtask

    task automatic check_state(input string tag, input logic [1:0] v, input int x0, input int x1,
                               input logic [1:0] t0, input logic [1:0] t1);
        check({tag, ".valid"}, int'(obs_valid), int'(v));
        check({tag, ".x0"}, int'(obs_x[9:0]), x0);
        check({tag, ".x1"}, int'(obs_x[19:10]), x1);
        check({tag, ".t0"}, int'(obs_type[1:0]), int'(t0));
        check({tag, ".t1"}, int'(obs_type[3:2]), int'(t1));
    endtask

    initial begin
        vecs[0]  = '{8,  1'b1, 3'd2, 5'd6,  0, 0, 2'b00, 0,   0,   2'd0, 2'd0};
        vecs[1]  = '{1,  1'b1, 3'd2, 5'd6,  1, 1, 2'b01, 640, 0,   2'd2, 2'd0};
        vecs[2]  = '{1,  1'b1, 3'd2, 5'd6,  0, 0, 2'b01, 638, 0,   2'd2, 2'd0};
        vecs[3]  = '{12, 1'b1, 3'd7, 5'd31, 0, 0, 2'b01, 554, 0,   2'd2, 2'd0};
        vecs[4]  = '{1,  1'b1, 3'd7, 5'd31, 1, 1, 2'b11, 547, 640, 2'd2, 2'd3};
        vecs[5]  = '{38, 1'b1, 3'd7, 5'd31, 0, 0, 2'b11, 281, 374, 2'd2, 2'd3};
        vecs[6]  = '{1,  1'b1, 3'd7, 5'd31, 0, 0, 2'b11, 274, 367, 2'd2, 2'd3};
        vecs[7]  = '{38, 1'b1, 3'd7, 5'd31, 0, 0, 2'b11, 8,   101, 2'd2, 2'd3};
        vecs[8]  = '{1,  1'b1, 3'd5, 5'd31, 0, 0, 2'b11, 3,   96,  2'd2, 2'd3};
        vecs[9]  = '{1,  1'b1, 3'd3, 5'd31, 0, 0, 2'b11, 0,   93,  2'd2, 2'd3};
        vecs[10] = '{1,  1'b1, 3'd3, 5'd31, 0, 0, 2'b10, 0,   90,  2'd2, 2'd3};
        vecs[11] = '{1,  1'b1, 3'd3, 5'd29, 1, 1, 2'b11, 640, 87,  2'd1, 2'd3};
        vecs[12] = '{12, 1'b1, 3'd7, 5'd29, 0, 0, 2'b11, 556, 3,   2'd1, 2'd3};
        vecs[13] = '{1,  1'b1, 3'd1, 5'd29, 0, 0, 2'b11, 555, 2,   2'd1, 2'd3};
        vecs[14] = '{1,  1'b1, 3'd3, 5'd29, 0, 0, 2'b01, 552, 0,   2'd1, 2'd3};
        vecs[15] = '{18, 1'b1, 3'd3, 5'd29, 0, 0, 2'b01, 498, 0,   2'd1, 2'd3};
        vecs[16] = '{10, 1'b0, 3'd3, 5'd29, 0, 0, 2'b01, 498, 0,   2'd1, 2'd3};
        vecs[17] = '{4,  1'b1, 3'd3, 5'd29, 0, 0, 2'b01, 486, 0,   2'd1, 2'd3};
        vecs[18] = '{1,  1'b1, 3'd3, 5'd29, 1, 1, 2'b11, 483, 640, 2'd1, 2'd1};
        vecs[19] = '{36, 1'b1, 3'd7, 5'd29, 0, 0, 2'b11, 231, 388, 2'd1, 2'd1};

        // Reset state
        spawn_seen = 0;
        step_seen  = 0;
        cycle(1'b0);
        cycle(1'b1);
        check("rst.step", int'(rng_step), 0);
        check("rst.spawn", int'(spawn_pulse), 0);
        check_state("rst", 2'b00, 0, 0, 2'd0, 2'd0);

        // Release: LOAD pulses rng_step exactly once, gap = 8 + 1
        sys_rst = 1'b0;
        cycle(1'b0);
        check("rel.step1", int'(rng_step), 1);
        rng_val = 5'd6;
        cycle(1'b0);
        check("rel.step2", int'(rng_step), 0);

        // Tick rows: spawn into free slots, movement edges, full-slot stall, freeze
        for (int r = 0; r < 20; r++) begin
            game_run   = vecs[r].run;
            speed      = vecs[r].spd;
            rng_val    = vecs[r].rng;
            spawn_seen = 0;
            step_seen  = 0;
            for (int k = 0; k < vecs[r].n; k++) begin
                cycle(1'b1);
                cycle(1'b0);
            end
            check($sformatf("row%0d.spawns", r), spawn_seen, vecs[r].spawns);
            check($sformatf("row%0d.steps", r), step_seen, vecs[r].steps);
            check_state($sformatf("row%0d", r), vecs[r].valid, vecs[r].x0, vecs[r].x1,
                        vecs[r].t0, vecs[r].t1);
        end

        // Mid-operation reset with both slots valid and a tick present
        sys_rst = 1'b1;
        game_run = 1'b1;
        cycle(1'b1);
        check("mrst.step", int'(rng_step), 0);
        check("mrst.spawn", int'(spawn_pulse), 0);
        check_state("mrst", 2'b00, 0, 0, 2'd0, 2'd0);

        // After release: single rng_step, gap reloads as 8 + 3 = 11 ticks
        sys_rst    = 1'b0;
        rng_val    = 5'd3;
        speed      = 3'd2;
        spawn_seen = 0;
        step_seen  = 0;
        cycle(1'b0);
        check("mrel.step", int'(rng_step), 1);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1);
            cycle(1'b0);
        end
        check("mrel.steps10", step_seen, 1);
        check("mrel.spawns10", spawn_seen, 0);
        cycle(1'b1);
        check("mrel.spawn11", int'(spawn_pulse), 1);
        check_state("mrel", 2'b01, 640, 0, 2'd3, 2'd0);
        cycle(1'b0);
        check("mrel.reload", int'(rng_step), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
